// File: rtl/ext_pipe_unit.sv
// Pipelined immediate-extension unit with valid/ready handshake, output register and skid buffer.
// Optional pop counter (xfer_cnt) enabled by defining EXT_PIPE_CNT_EN.
module ext_pipe_unit #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHAMT = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
`ifdef EXT_PIPE_CNT_EN
   ,
   output logic [15:0]      xfer_cnt
`endif
);

   if (IN_W < 1 || IN_W >= OUT_W) begin : g_bad_in_w
      $error("ext_pipe_unit: IN_W must be >= 1 and < OUT_W");
   end
   if (SHAMT < 0 || SHAMT >= OUT_W) begin : g_bad_shamt
      $error("ext_pipe_unit: SHAMT must be < OUT_W");
   end
   if (TAG_W < 1) begin : g_bad_tag_w
      $error("ext_pipe_unit: TAG_W must be >= 1");
   end

   function automatic logic [OUT_W-1:0] ext_f(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
      logic signed [OUT_W-1:0] sx;
      logic        [OUT_W-1:0] res;
      sx = signed'({{(OUT_W-IN_W){imm[IN_W-1]}}, imm});
      case (mode)
         2'd0:    res = {{(OUT_W-IN_W){1'b0}}, imm};
         2'd1:    res = sx;
         2'd2:    res = {imm, {(OUT_W-IN_W){1'b0}}};
         default: res = sx <<< SHAMT;
      endcase
      return res;
   endfunction

   logic             vld_p0;
   logic [OUT_W-1:0] data_p0;
   logic [TAG_W-1:0] tag_p0;
   logic             pop;

   logic             vld_p1;
   logic [OUT_W-1:0] data_p1;
   logic [TAG_W-1:0] tag_p1;

   logic             skid_vld;
   logic [OUT_W-1:0] skid_data;
   logic [TAG_W-1:0] skid_tag;

   // Stage p0: combinational extension of the accepted input
   assign in_ready = ~skid_vld;
   assign vld_p0   = in_valid & in_ready;
   assign data_p0  = ext_f(in_imm, in_mode);
   assign tag_p0   = in_tag;
   assign pop      = vld_p1 & out_ready;

   // Stage p1: output register, backed by a one-entry skid buffer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1    <= 1'b0;
         data_p1   <= '0;
         tag_p1    <= '0;
         skid_vld  <= 1'b0;
         skid_data <= '0;
         skid_tag  <= '0;
      end else if (pop && skid_vld) begin
         data_p1  <= skid_data;
         tag_p1   <= skid_tag;
         skid_vld <= 1'b0;
      end else if (vld_p0 && (!vld_p1 || pop)) begin
         vld_p1  <= 1'b1;
         data_p1 <= data_p0;
         tag_p1  <= tag_p0;
      end else if (vld_p0) begin
         skid_vld  <= 1'b1;
         skid_data <= data_p0;
         skid_tag  <= tag_p0;
      end else if (pop) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign out_data  = data_p1;
   assign out_tag   = tag_p1;

`ifdef EXT_PIPE_CNT_EN
   logic [15:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Bench for ext_pipe_unit: directed table, handshake corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_ext_pipe_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag, out_tag;
   logic [31:0] out_data;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [11:0] b_in_imm;
   logic [1:0]  b_in_mode;
   logic [4:0]  b_in_tag, b_out_tag;
   logic [19:0] b_out_data;

`ifdef EXT_PIPE_CNT_EN
   logic [15:0] xfer_cnt, b_xfer_cnt;
`endif

   ext_pipe_unit dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
`ifdef EXT_PIPE_CNT_EN
      , .xfer_cnt(xfer_cnt)
`endif
   );

   ext_pipe_unit #(.IN_W(12), .OUT_W(20), .SHAMT(1), .TAG_W(5)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_imm(b_in_imm), .in_mode(b_in_mode), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_data(b_out_data), .out_tag(b_out_tag)
`ifdef EXT_PIPE_CNT_EN
      , .xfer_cnt(b_xfer_cnt)
`endif
   );

   int nvec  = 0;
   int nfail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Extension computed arithmetically from the mode definitions.
   function automatic logic [63:0] ref_ext(input longint imm, input int mode,
                                           input int in_w, input int out_w, input int shamt);
      longint mask;
      longint s;
      mask = (longint'(1) << out_w) - 1;
      s = (imm >= (longint'(1) << (in_w - 1))) ? imm - (longint'(1) << in_w) : imm;
      case (mode)
         0:       return 64'(imm & mask);
         1:       return 64'(s & mask);
         2:       return 64'((imm << (out_w - in_w)) & mask);
         default: return 64'((s << shamt) & mask);
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] imm;
      logic [1:0]  mode;
      logic [4:0]  tag;
      logic [31:0] exp;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
   } item_t;

   vec_t  tbl[4];
   item_t q[$];

   initial begin
      tbl[0] = '{16'h8001, 2'd0, 5'd3, 32'h00008001};
      tbl[1] = '{16'h8001, 2'd1, 5'd3, 32'hFFFF8001};
      tbl[2] = '{16'h8001, 2'd2, 5'd3, 32'h80010000};
      tbl[3] = '{16'h8001, 2'd3, 5'd3, 32'hFFFE0004};

      rst = 1'b1;
      in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_imm = '0; b_in_mode = '0; b_in_tag = '0; b_out_ready = 1'b1;
      #2;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_in_ready",  64'(in_ready),  64'd1);
      chk("reset_out_data",  64'(out_data),  64'd0);
      chk("reset_out_tag",   64'(out_tag),   64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Single items per mode
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_imm = tbl[i].imm; in_mode = tbl[i].mode; in_tag = tbl[i].tag;
         tick();
         in_valid = 1'b0;
         chk("mode_valid", 64'(out_valid), 64'd1);
         chk("mode_data",  64'(out_data),  64'(tbl[i].exp));
         chk("mode_tag",   64'(out_tag),   64'(tbl[i].tag));
         tick();
         chk("mode_drain", 64'(out_valid), 64'd0);
      end

      // Back-to-back stream
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_imm = 16'(k + 1); in_mode = 2'd1; in_tag = 5'(k);
         tick();
         chk("stream_data",     64'(out_data), 64'(k + 1));
         chk("stream_valid",    64'(out_valid), 64'd1);
         chk("stream_in_ready", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 64'(out_valid), 64'd0);

      // Back-pressure into the skid buffer
      in_valid = 1'b1; in_imm = 16'h0010; in_mode = 2'd0; in_tag = 5'd1;
      tick();
      out_ready = 1'b0; in_imm = 16'h0020; in_tag = 5'd2;
      tick();
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      in_imm = 16'h0030; in_tag = 5'd4;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold_data",  64'(out_data),  64'h10);
         chk("bp_hold_tag",   64'(out_tag),   64'd1);
         chk("bp_hold_ready", 64'(in_ready),  64'd0);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("bp_b_data",   64'(out_data),  64'h20);
      chk("bp_b_tag",    64'(out_tag),   64'd2);
      chk("bp_in_ready", 64'(in_ready),  64'd1);
      tick();
      chk("bp_drain", 64'(out_valid), 64'd0);

      // Asynchronous reset with both registers full
      out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h0001; in_mode = 2'd1;
      tick();
      in_imm = 16'h0002;
      tick();
      in_valid = 1'b0;
      chk("full_in_ready", 64'(in_ready), 64'd0);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_in_ready",  64'(in_ready),  64'd1);
      chk("arst_out_data",  64'(out_data),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      out_ready = 1'b1; in_valid = 1'b1; in_imm = 16'h7FFF; in_mode = 2'd1; in_tag = 5'd9;
      tick();
      in_valid = 1'b0;
      chk("post_rst_valid", 64'(out_valid), 64'd1);
      chk("post_rst_data",  64'(out_data),  64'h00007FFF);
      tick();
      chk("post_rst_drain", 64'(out_valid), 64'd0);

      // Narrow parametrisation
      b_in_valid = 1'b1; b_in_imm = 12'h800; b_in_mode = 2'd3; b_in_tag = 5'd7;
      tick();
      chk("b_mode3", 64'(b_out_data), 64'hFF000);
      b_in_mode = 2'd2;
      tick();
      chk("b_mode2", 64'(b_out_data), 64'h80000);
      chk("b_tag",   64'(b_out_tag),  64'd7);
      b_in_valid = 1'b0;
      tick();
      chk("b_drain", 64'(b_out_valid), 64'd0);

      // Randomized run against the queue model
      for (int c = 0; c < 3000; c++) begin
         logic        acc, pp;
         logic [63:0] e;
         item_t       it;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_imm    = 16'($urandom);
         in_mode   = 2'($urandom);
         in_tag    = 5'($urandom);
         acc = in_valid && (q.size() < 2);
         pp  = out_ready && (q.size() > 0);
         e = ref_ext(longint'(in_imm), int'(in_mode), 16, 32, 2);
         it.data = e[31:0];
         it.tag  = in_tag;
         tick();
         if (pp) void'(q.pop_front());
         if (acc) q.push_back(it);
         chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
         chk("rnd_in_ready",  64'(in_ready),  64'(q.size() < 2));
         if (q.size() > 0) begin
            chk("rnd_data", 64'(out_data), 64'(q[0].data));
            chk("rnd_tag",  64'(out_tag),  64'(q[0].tag));
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();

`ifdef EXT_PIPE_CNT_EN
      rst = 1'b1;
      #2;
      chk("cnt_reset", 64'(xfer_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      in_valid = 1'b1; out_ready = 1'b1; in_mode = 2'd0;
      for (int k = 0; k < 65538; k++) tick();
      in_valid = 1'b0;
      chk("cnt_wrap", 64'(xfer_cnt), 64'd1);
      rst = 1'b1;
      #1;
      chk("cnt_rst_again", 64'(xfer_cnt), 64'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
